// File: rtl/fwd_operand_sel.sv
// Register-fetch operand select: picks the youngest matching forwarding entry per
// source operand (ra/rb/rc), else register-file data, and registers it for execute.
module fwd_operand_sel #(
  parameter int DW     = 128,
  parameter int AW     = 7,
  parameter bit FWD_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [AW-1:0]    addr_ra,
  input  logic [AW-1:0]    addr_rb,
  input  logic [AW-1:0]    addr_rc,
  input  logic [DW-1:0]    rf_ra,
  input  logic [DW-1:0]    rf_rb,
  input  logic [DW-1:0]    rf_rc,
  input  logic [0:AW+DW-1] fw_chk_even_1,
  input  logic [0:AW+DW-1] fw_chk_even_2,
  input  logic [0:AW+DW-1] fw_chk_even_3,
  input  logic [0:AW+DW-1] fw_chk_even_4,
  input  logic [0:AW+DW-1] fw_chk_even_5,
  input  logic [0:AW+DW-1] fw_chk_odd_1,
  input  logic [0:AW+DW-1] fw_chk_odd_2,
  input  logic [0:AW+DW-1] fw_chk_odd_3,
  input  logic [0:AW+DW-1] fw_chk_odd_4,
  input  logic [0:AW+DW-1] fw_chk_odd_5,
  output logic [DW-1:0]    op_ra,
  output logic [DW-1:0]    op_rb,
  output logic [DW-1:0]    op_rc,
  output logic             op_valid,
  output logic [2:0]       fwd_hit,
  output logic [3:0]       fwd_src_ra,
  output logic [3:0]       fwd_src_rb,
  output logic [3:0]       fwd_src_rc
);

  localparam logic [3:0] SRC_NONE = 4'd15;

  typedef struct packed {
    logic          hit;
    logic [3:0]    src;
    logic [DW-1:0] data;
  } sel_t;

  // Slot index equals the reported source code: 0..4 even1..5, 5..9 odd1..5.
  logic [AW-1:0] slot_addr [10];
  logic [DW-1:0] slot_data [10];

  assign slot_addr[0] = fw_chk_even_1[0:AW-1];
  assign slot_addr[1] = fw_chk_even_2[0:AW-1];
  assign slot_addr[2] = fw_chk_even_3[0:AW-1];
  assign slot_addr[3] = fw_chk_even_4[0:AW-1];
  assign slot_addr[4] = fw_chk_even_5[0:AW-1];
  assign slot_addr[5] = fw_chk_odd_1[0:AW-1];
  assign slot_addr[6] = fw_chk_odd_2[0:AW-1];
  assign slot_addr[7] = fw_chk_odd_3[0:AW-1];
  assign slot_addr[8] = fw_chk_odd_4[0:AW-1];
  assign slot_addr[9] = fw_chk_odd_5[0:AW-1];

  assign slot_data[0] = fw_chk_even_1[AW:AW+DW-1];
  assign slot_data[1] = fw_chk_even_2[AW:AW+DW-1];
  assign slot_data[2] = fw_chk_even_3[AW:AW+DW-1];
  assign slot_data[3] = fw_chk_even_4[AW:AW+DW-1];
  assign slot_data[4] = fw_chk_even_5[AW:AW+DW-1];
  assign slot_data[5] = fw_chk_odd_1[AW:AW+DW-1];
  assign slot_data[6] = fw_chk_odd_2[AW:AW+DW-1];
  assign slot_data[7] = fw_chk_odd_3[AW:AW+DW-1];
  assign slot_data[8] = fw_chk_odd_4[AW:AW+DW-1];
  assign slot_data[9] = fw_chk_odd_5[AW:AW+DW-1];

  function automatic logic addr_match(input logic [AW-1:0] op_addr,
                                      input logic [AW-1:0] s_addr);
    return (s_addr == op_addr) && (FWD_R0 || (op_addr != '0));
  endfunction

  // Scan oldest to youngest so the last hit wins; even is checked after odd
  // at each age so it takes precedence at equal age.
  function automatic sel_t pick(input logic [AW-1:0] op_addr,
                                input logic [DW-1:0] rf_data);
    sel_t r;
    r.hit  = 1'b0;
    r.src  = SRC_NONE;
    r.data = rf_data;
    for (int k = 4; k >= 0; k--) begin
      if (addr_match(op_addr, slot_addr[k+5])) begin
        r.hit  = 1'b1;
        r.src  = 4'(k + 5);
        r.data = slot_data[k+5];
      end
      if (addr_match(op_addr, slot_addr[k])) begin
        r.hit  = 1'b1;
        r.src  = 4'(k);
        r.data = slot_data[k];
      end
    end
    return r;
  endfunction

  // Stage p0: combinational operand selection on current-cycle inputs.
  sel_t sel_ra_p0, sel_rb_p0, sel_rc_p0;

  always_comb begin
    sel_ra_p0 = pick(addr_ra, rf_ra);
    sel_rb_p0 = pick(addr_rb, rf_rb);
    sel_rc_p0 = pick(addr_rc, rf_rc);
  end

  // Stage p1: execute-facing registers.
  logic [DW-1:0] ra_p1, rb_p1, rc_p1;
  logic [3:0]    src_ra_p1, src_rb_p1, src_rc_p1;
  logic [2:0]    hit_p1;
  logic          vld_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      ra_p1     <= '0;
      rb_p1     <= '0;
      rc_p1     <= '0;
      hit_p1    <= '0;
      src_ra_p1 <= SRC_NONE;
      src_rb_p1 <= SRC_NONE;
      src_rc_p1 <= SRC_NONE;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        ra_p1     <= sel_ra_p0.data;
        rb_p1     <= sel_rb_p0.data;
        rc_p1     <= sel_rc_p0.data;
        hit_p1    <= {sel_rc_p0.hit, sel_rb_p0.hit, sel_ra_p0.hit};
        src_ra_p1 <= sel_ra_p0.src;
        src_rb_p1 <= sel_rb_p0.src;
        src_rc_p1 <= sel_rc_p0.src;
      end
    end
  end

  assign op_ra      = ra_p1;
  assign op_rb      = rb_p1;
  assign op_rc      = rc_p1;
  assign op_valid   = vld_p1;
  assign fwd_hit    = hit_p1;
  assign fwd_src_ra = src_ra_p1;
  assign fwd_src_rb = src_rb_p1;
  assign fwd_src_rc = src_rc_p1;

endmodule
